prbs_seq_ctrl: RTL

Command-driven sequencer for the 31-bit PRBS generator (x^31 + x^28 + 1, shift-left, feedback into bit 0 from bits 30 and 27).
- Accepts load-seed, run-N-bits and free-run commands, and streams the generator MSB over a valid/ready output.
- Advances the LFSR only on an accepted output bit, so downstream backpressure never skips or repeats sequence bits.
- Sits between the tile's command/config logic and any serial consumer of the pseudo-random stream.

---
 rtl/prbs_pkg.sv | 18 +
 rtl/prbs_step.sv | 30 +++
 rtl/prbs_seq_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared encodings and default constants for the PRBS sequencer
package prbs_pkg;
    localparam int PRBS_WIDTH = 31;
    localparam int PRBS_TAP   = 27;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_RUN_N = 2'b01,
        OP_FREE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FREE = 2'b10
    } state_e;
endpackage

// File: rtl/prbs_step.sv
// prbs_step: LFSR register with zero-guarded load and single-step enable
module prbs_step
    import prbs_pkg::*;
#(
    parameter int WIDTH = PRBS_WIDTH,
    parameter int TAP   = PRBS_TAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o,
    output logic             msb_o
);
    logic [WIDTH-1:0] lfsr_q;

    // a zero seed would lock the LFSR, so it is replaced by 1; load wins over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= WIDTH'(1);
        else if (load_i)
            lfsr_q <= (seed_i == '0) ? WIDTH'(1) : seed_i;
        else if (step_i)
            lfsr_q <= {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[TAP]};
    end

    assign state_o = lfsr_q;
    assign msb_o   = lfsr_q[WIDTH-1];
endmodule

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl: command FSM streaming PRBS bits over valid/ready
module prbs_seq_ctrl
    import prbs_pkg::*;
#(
    parameter int WIDTH = PRBS_WIDTH,
    parameter int TAP   = PRBS_TAP,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err_seed,
    output logic [WIDTH-1:0] lfsr_state
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             load;
    logic             hs;
    logic             cmd_acc;

    assign cmd_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q != ST_IDLE);
    assign busy      = out_valid;
    assign hs        = out_valid && out_ready;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign done      = done_q;
    assign err_seed  = err_q;

    prbs_step #(.WIDTH(WIDTH), .TAP(TAP)) u_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .seed_i (seed_in),
        .step_i (hs),
        .state_o(lfsr_state),
        .msb_o  (out_bit)
    );

    // state, run counter and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // next state: commands only in IDLE; RUN leaves on its last handshake since cnt is never below 1 there
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (op_e'(cmd_op))
                        OP_LOAD: begin
                            load   = 1'b1;
                            done_d = 1'b1;
                            err_d  = (seed_in == '0);
                        end
                        OP_RUN_N: begin
                            cnt_d   = cmd_arg;
                            done_d  = (cmd_arg == '0);
                            state_d = (cmd_arg == '0) ? ST_IDLE : ST_RUN;
                        end
                        OP_FREE: state_d = ST_FREE;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = hs ? cnt_q - CNT_W'(1) : cnt_q;
                if (abort || (hs && cnt_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_FREE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
